// File: rtl/inv_shift_row_byte_sub_if.sv
// Block handshake and dual-port statemt memory bus for the AES inverse
// ShiftRows/SubBytes stage.
//   ap_start          : start request from the controller (level)
//   ap_done/ap_ready  : one-cycle completion pulse from the block
//   ap_idle           : block idle and no start pending
//   statemt_*0/1      : two 1-cycle-latency memory ports (addr/ce/we/d out, q in)
// The slave modport is the stage itself; master is the controller/memory side.
interface inv_shift_row_byte_sub_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [ADDR_W-1:0] statemt_address0;
    logic [ADDR_W-1:0] statemt_address1;
    logic              statemt_ce0;
    logic              statemt_ce1;
    logic              statemt_we0;
    logic              statemt_we1;
    logic [DATA_W-1:0] statemt_d0;
    logic [DATA_W-1:0] statemt_d1;
    logic [DATA_W-1:0] statemt_q0;
    logic [DATA_W-1:0] statemt_q1;

    modport slave (
        input  ap_start,
        output ap_done, ap_idle, ap_ready,
        output statemt_address0, statemt_address1,
        output statemt_ce0, statemt_ce1, statemt_we0, statemt_we1,
        output statemt_d0, statemt_d1,
        input  statemt_q0, statemt_q1
    );

    modport master (
        output ap_start,
        input  ap_done, ap_idle, ap_ready,
        input  statemt_address0, statemt_address1,
        input  statemt_ce0, statemt_ce1, statemt_we0, statemt_we1,
        input  statemt_d0, statemt_d1,
        output statemt_q0, statemt_q1
    );
endinterface

// File: rtl/inv_shift_row_byte_sub.sv
// AES decrypt stage: in-place InvShiftRows + InvSubBytes on the 16 state
// bytes held in statemt[0..15] (byte (r,c) at address r+4c, bits [7:0]).
// Reads all 16 bytes into a snapshot buffer (RD), then writes every address
// with InvSbox of its shifted source byte (WR), then pulses done/ready.
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : ap_* handshake and the two statemt memory ports
module inv_shift_row_byte_sub #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    inv_shift_row_byte_sub_if.slave bus
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned N_BYTES = 16;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    // Standard AES inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    // Buffer index feeding destination address a: row r, column (c - r) mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] a);
        return {2'(a[3:2] - a[1:0]), a[1:0]};
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BYTE_W-1:0]  r_buf [N_BYTES];
    logic               r_ce;
    logic               r_we;
    logic               r_done;
    logic [3:0]         r_addr0;
    logic [3:0]         r_addr1;
    logic [BYTE_W-1:0]  r_d0;
    logic [BYTE_W-1:0]  r_d1;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BYTE_W-1:0]  w_buf_nxt [N_BYTES];
    logic [2:0]         w_rd_slot;
    logic               w_ce_nxt;
    logic               w_we_nxt;
    logic               w_done_nxt;
    logic [3:0]         w_addr0_nxt;
    logic [3:0]         w_addr1_nxt;
    logic [BYTE_W-1:0]  w_d0_nxt;
    logic [BYTE_W-1:0]  w_d1_nxt;
    logic               w_unused_q;

    // Only the low byte of each word carries state.
    assign w_unused_q = ^{bus.statemt_q0[DATA_W-1:BYTE_W], bus.statemt_q1[DATA_W-1:BYTE_W]};

    // Read data returns one cycle after its address, so RD step n captures pair n-1.
    assign w_rd_slot = 3'(r_cnt - 4'd1);

    // Next state, counter and buffer contents.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
        case (r_state)
            S_IDLE: begin
                if (bus.ap_start) begin
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = '0;
                end
            end
            S_RD: begin
                if (r_cnt != '0) begin
                    w_buf_nxt[{w_rd_slot, 1'b0}] = bus.statemt_q0[BYTE_W-1:0];
                    w_buf_nxt[{w_rd_slot, 1'b1}] = bus.statemt_q1[BYTE_W-1:0];
                end
                if (r_cnt == 4'd8) begin
                    w_state_nxt = S_WR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_WR: begin
                if (r_cnt == 4'd7) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming state; write data uses the buffer
    // including the pair captured on the same edge.
    always_comb begin
        w_ce_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_addr0_nxt = '0;
        w_addr1_nxt = '0;
        w_d0_nxt    = '0;
        w_d1_nxt    = '0;
        case (w_state_nxt)
            S_RD: begin
                if (!w_cnt_nxt[3]) begin
                    w_ce_nxt    = 1'b1;
                    w_addr0_nxt = {w_cnt_nxt[2:0], 1'b0};
                    w_addr1_nxt = {w_cnt_nxt[2:0], 1'b1};
                end
            end
            S_WR: begin
                w_ce_nxt    = 1'b1;
                w_we_nxt    = 1'b1;
                w_addr0_nxt = {w_cnt_nxt[2:0], 1'b0};
                w_addr1_nxt = {w_cnt_nxt[2:0], 1'b1};
                w_d0_nxt    = inv_sbox(w_buf_nxt[src_idx(w_addr0_nxt)]);
                w_d1_nxt    = inv_sbox(w_buf_nxt[src_idx(w_addr1_nxt)]);
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_ce_nxt = 1'b0;
            end
        endcase
    end

    // FSM, snapshot buffer and registered outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            for (int i = 0; i < int'(N_BYTES); i++) begin
                r_buf[i] <= '0;
            end
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_d0    <= '0;
            r_d1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
            r_ce    <= w_ce_nxt;
            r_we    <= w_we_nxt;
            r_done  <= w_done_nxt;
            r_addr0 <= w_addr0_nxt;
            r_addr1 <= w_addr1_nxt;
            r_d0    <= w_d0_nxt;
            r_d1    <= w_d1_nxt;
        end
    end

    assign bus.ap_done          = r_done;
    assign bus.ap_ready         = r_done;
    assign bus.ap_idle          = (r_state == S_IDLE) && !bus.ap_start;
    assign bus.statemt_ce0      = r_ce;
    assign bus.statemt_ce1      = r_ce;
    assign bus.statemt_we0      = r_we;
    assign bus.statemt_we1      = r_we;
    assign bus.statemt_address0 = ADDR_W'(r_addr0);
    assign bus.statemt_address1 = ADDR_W'(r_addr1);
    assign bus.statemt_d0       = DATA_W'(r_d0);
    assign bus.statemt_d1       = DATA_W'(r_d1);

endmodule

// File: tb/tb_inv_shift_row_byte_sub.sv
// Scoreboard bench for inv_shift_row_byte_sub: a behavioural dual-port
// memory, a driver that queues the expected write stream per operation, and
// a negedge monitor that checks every memory write against the queue.
module tb_inv_shift_row_byte_sub;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    inv_shift_row_byte_sub_if bus_if ();

    inv_shift_row_byte_sub dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus_if.slave)
    );

    always #5 ap_clk = ~ap_clk;

    // Memory model: 1-cycle read latency, plus a bench-side load port.
    logic [31:0] mem [32];
    logic        ld_en   = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge ap_clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (bus_if.statemt_ce0) begin
            if (bus_if.statemt_we0) mem[bus_if.statemt_address0] <= bus_if.statemt_d0;
            else                    bus_if.statemt_q0 <= mem[bus_if.statemt_address0];
        end
        if (bus_if.statemt_ce1) begin
            if (bus_if.statemt_we1) mem[bus_if.statemt_address1] <= bus_if.statemt_d1;
            else                    bus_if.statemt_q1 <= mem[bus_if.statemt_address1];
        end
    end

    // Hand-copied InvSbox values for inputs 0x00..0x0F, and InvSbox applied twice.
    logic [7:0] sb1 [16] = '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
                             8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb};
    logic [7:0] sb2 [16] = '{8'h48, 8'h40, 8'h58, 8'hb5, 8'h08, 8'h24, 8'h29, 8'h76,
                             8'hf4, 8'h72, 8'h71, 8'hdf, 8'h91, 8'h7e, 8'h0d, 8'h63};

    function automatic int src1(input int a);
        int r = a % 4;
        int c = a / 4;
        return r + 4 * ((c - r) & 3);
    endfunction

    function automatic int src2(input int a);
        int r = a % 4;
        int c = a / 4;
        return r + 4 * ((c - 2 * r) & 3);
    endfunction

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_port(input logic ce, input logic we, input logic [4:0] addr,
                            input logic [31:0] d);
        exp_t e;
        if (ce) begin
            chk("addr_bit4", 32'(addr[4]), 32'd0);
            if (we) begin
                wr_cnt++;
                chk("we_before_all_reads", 32'(rd_cnt), 32'd16);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %h data %h with empty queue", addr, d);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", 32'(addr), 32'(e.addr));
                    chk("wr_data", d, e.data);
                end
            end else begin
                rd_cnt++;
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                mon_port(bus_if.statemt_ce0, bus_if.statemt_we0, bus_if.statemt_address0, bus_if.statemt_d0);
                mon_port(bus_if.statemt_ce1, bus_if.statemt_we1, bus_if.statemt_address1, bus_if.statemt_d1);
                if (bus_if.ap_done) begin
                    chk("reads_per_op", 32'(rd_cnt), 32'd16);
                    chk("writes_per_op", 32'(wr_cnt), 32'd16);
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic load_word(input int a, input logic [31:0] v);
        @(posedge ap_clk);
        #1;
        ld_en   = 1'b1;
        ld_addr = 5'(a);
        ld_data = v;
        @(posedge ap_clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic push_exp(input int a, input logic [31:0] d);
        exp_t e;
        e.addr = 5'(a);
        e.data = d;
        sb_q.push_back(e);
    endtask

    // One start pulse; done must appear only in the interval after edge 17.
    task automatic run_op(input string tag);
        int done_at = -1;
        int pulses  = 0;
        @(posedge ap_clk);
        #1 bus_if.ap_start = 1'b1;
        @(posedge ap_clk);
        #1 bus_if.ap_start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus_if.ap_done) begin
                pulses++;
                if (done_at < 0) done_at = i;
                chk({tag, "_ready_with_done"}, 32'(bus_if.ap_ready), 32'd1);
            end
        end
        chk({tag, "_done_cycle"}, 32'(done_at), 32'd17);
        chk({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_queue_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done1;
        int done2;
        int idle_seen;
        int found;
        bus_if.ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_idle", 32'(bus_if.ap_idle), 32'd1);
        chk("rst_done", 32'(bus_if.ap_done), 32'd0);
        chk("rst_ready", 32'(bus_if.ap_ready), 32'd0);
        chk("rst_ce", 32'({bus_if.statemt_ce0, bus_if.statemt_ce1, bus_if.statemt_we0, bus_if.statemt_we1}), 32'd0);
        chk("rst_addr", 32'({bus_if.statemt_address0, bus_if.statemt_address1}), 32'd0);
        chk("rst_d0", bus_if.statemt_d0, 32'd0);
        ap_rst_n = 1'b1;

        // All bytes 0x63 -> all zero.
        for (int k = 0; k < 16; k++) load_word(k, 32'h0000_0063);
        for (int a = 0; a < 16; a++) push_exp(a, 32'h0);
        run_op("t1");
        for (int a = 0; a < 16; a++) chk("t1_readback", mem[a], 32'h0);

        // Single 0x63 at (1,0) lands at (1,1) = word 5.
        for (int k = 0; k < 16; k++) load_word(k, (k == 1) ? 32'h63 : 32'h52);
        for (int a = 0; a < 16; a++) push_exp(a, (a == 5) ? 32'h00 : 32'h48);
        run_op("t2");

        // Distinct bytes with junk upper bits.
        for (int k = 0; k < 16; k++) load_word(k, 32'hABCDEF00 + 32'(k));
        for (int a = 0; a < 16; a++) push_exp(a, {24'h0, sb1[src1(a)]});
        run_op("t3");
        chk("t3_word0", mem[0], 32'h52);
        chk("t3_word4", mem[4], 32'h30);
        chk("t3_word1", mem[1], 32'hF3);

        // Back-to-back with start held high: second pass yields the double transform.
        for (int k = 0; k < 16; k++) load_word(k, 32'hABCDEF00 + 32'(k));
        for (int a = 0; a < 16; a++) push_exp(a, {24'h0, sb1[src1(a)]});
        for (int a = 0; a < 16; a++) push_exp(a, {24'h0, sb2[src2(a)]});
        done1 = -1;
        done2 = -1;
        idle_seen = 0;
        @(posedge ap_clk);
        #1 bus_if.ap_start = 1'b1;
        @(posedge ap_clk);
        for (int i = 1; i <= 45 && done2 < 0; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus_if.ap_idle) idle_seen++;
            if (bus_if.ap_done) begin
                if (done1 < 0) done1 = i;
                else           done2 = i;
            end
        end
        bus_if.ap_start = 1'b0;
        chk("b2b_first_done", 32'(done1), 32'd17);
        chk("b2b_spacing", 32'(done2 - done1), 32'd19);
        chk("b2b_idle_never", 32'(idle_seen), 32'd0);
        repeat (3) @(posedge ap_clk);
        #1;
        chk("b2b_idle_after", 32'(bus_if.ap_idle), 32'd1);
        chk("b2b_queue_drained", 32'(sb_q.size()), 32'd0);

        // Reset during WR right after the writes of words 6/7 commit.
        for (int k = 0; k < 16; k++) load_word(k, 32'hABCDEF00 + 32'(k));
        for (int a = 0; a < 16; a++) push_exp(a, {24'h0, sb1[src1(a)]});
        @(posedge ap_clk);
        #1 bus_if.ap_start = 1'b1;
        @(posedge ap_clk);
        #1 bus_if.ap_start = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus_if.statemt_we0 && bus_if.statemt_address0 == 5'd6) found = 1;
        end
        chk("rst_wr_cnt3_reached", 32'(found), 32'd1);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("midrst_ce_we", 32'({bus_if.statemt_ce0, bus_if.statemt_ce1, bus_if.statemt_we0, bus_if.statemt_we1}), 32'd0);
        chk("midrst_idle", 32'(bus_if.ap_idle), 32'd1);
        chk("midrst_done", 32'(bus_if.ap_done), 32'd0);
        chk("midrst_writes_done", 32'(sb_q.size()), 32'd8);
        sb_q.delete();
        for (int a = 0; a < 16; a++)
            chk("midrst_mem", mem[a], (a < 8) ? {24'h0, sb1[src1(a)]} : 32'hABCDEF00 + 32'(a));
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // Normal operation after the aborted one.
        for (int k = 0; k < 16; k++) load_word(k, 32'h0000_0063);
        for (int a = 0; a < 16; a++) push_exp(a, 32'h0);
        run_op("t6");

        repeat (3) @(posedge ap_clk);
        #1;
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
